// File: rtl/multicycle_adder.sv
// Sliced multi-cycle add/subtract unit: SLICE bits per clock with a registered carry between slices.
// Optional accumulate mode (Acc port, Sum as operand A) enabled by defining MULTICYCLE_ADDER_ACCUM_EN.
module multicycle_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SLICE = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             Sub,
`ifdef MULTICYCLE_ADDER_ACCUM_EN
  input  logic             Acc,
`endif
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             OV,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADD, S_DONE} state_t;

  state_t            state_q;
  logic [IW-1:0]     idx_q;
  logic              carry_q;
  logic [WIDTH-1:0]  opa_q, opb_q, res_q;
  logic [WIDTH-1:0]  sum_q;
  logic              co_q, ov_q, busy_q, done_q;

  logic [SLICE-1:0]  a_sl, b_sl;
  logic [SLICE:0]    sl_sum;
  logic [WIDTH-1:0]  res_d;
  logic [WIDTH-1:0]  opa_d;
  logic              ov_d;

  always_comb begin
    a_sl   = opa_q[idx_q*SLICE +: SLICE];
    b_sl   = opb_q[idx_q*SLICE +: SLICE];
    sl_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, carry_q};
    res_d  = res_q;
    res_d[idx_q*SLICE +: SLICE] = sl_sum[SLICE-1:0];
    // Carry into the MSB is recovered from the MSB sum bit, so SLICE=1 needs no special case
    ov_d   = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_sum[SLICE-1] ^ sl_sum[SLICE];
`ifdef MULTICYCLE_ADDER_ACCUM_EN
    opa_d  = Acc ? sum_q : A;
`else
    opa_d  = A;
`endif
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ov_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (Run) begin
            opa_q   <= opa_d;
            opb_q   <= Sub ? ~B : B;
            carry_q <= Sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          res_q   <= res_d;
          carry_q <= sl_sum[SLICE];
          if (idx_q == LAST) begin
            idx_q   <= '0;
            sum_q   <= res_d;
            co_q    <= sl_sum[SLICE];
            ov_q    <= ov_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Sum  = sum_q;
  assign CO   = co_q;
  assign OV   = ov_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: three configurations (16/4, 32/8, 32/32) against an arithmetic reference.
module tb_multicycle_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sub, acc;
  logic        run0, run1, run2;
  logic [31:0] a_in, b_in;
  logic [15:0] sum0;
  logic [31:0] sum1, sum2;
  logic        co0, co1, co2, ov0, ov1, ov2;
  logic        busy0, busy1, busy2, done0, done1, done2;

  multicycle_adder #(.WIDTH(16), .SLICE(4)) dut0 (
    .Clk(clk), .Reset(rst), .Run(run0), .Sub(sub),
`ifdef MULTICYCLE_ADDER_ACCUM_EN
    .Acc(acc),
`endif
    .A(a_in[15:0]), .B(b_in[15:0]), .Sum(sum0), .CO(co0), .OV(ov0), .Busy(busy0), .Done(done0));

  multicycle_adder #(.WIDTH(32), .SLICE(8)) dut1 (
    .Clk(clk), .Reset(rst), .Run(run1), .Sub(sub),
`ifdef MULTICYCLE_ADDER_ACCUM_EN
    .Acc(acc),
`endif
    .A(a_in), .B(b_in), .Sum(sum1), .CO(co1), .OV(ov1), .Busy(busy1), .Done(done1));

  multicycle_adder #(.WIDTH(32), .SLICE(32)) dut2 (
    .Clk(clk), .Reset(rst), .Run(run2), .Sub(sub),
`ifdef MULTICYCLE_ADDER_ACCUM_EN
    .Acc(acc),
`endif
    .A(a_in), .B(b_in), .Sum(sum2), .CO(co2), .OV(ov2), .Busy(busy2), .Done(done2));

  int          sel;
  logic [31:0] o_sum;
  logic        o_co, o_ov, o_busy, o_done;

  always_comb begin
    o_sum = '0; o_co = 1'b0; o_ov = 1'b0; o_busy = 1'b0; o_done = 1'b0;
    case (sel)
      0: begin o_sum = {16'h0, sum0}; o_co = co0; o_ov = ov0; o_busy = busy0; o_done = done0; end
      1: begin o_sum = sum1; o_co = co1; o_ov = ov1; o_busy = busy1; o_done = done1; end
      default: begin o_sum = sum2; o_co = co2; o_ov = ov2; o_busy = busy2; o_done = done2; end
    endcase
  end

  int vectors = 0;
  int miscompares = 0;

  int unsigned     W  [3] = '{16, 32, 32};
  int unsigned     NS [3] = '{4, 4, 1};
  longint unsigned prev_sum [3];
  bit              prev_co  [3];
  bit              prev_ov  [3];

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (dut%0d): observed 0x%0h expected 0x%0h", tag, sel, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic and sign-rule overflow, no slicing
  function automatic void model(int unsigned w, bit sb, longint unsigned a, longint unsigned b,
                                output longint unsigned s, output bit co, output bit ov);
    longint unsigned mask, t;
    bit sa, sbb, ss;
    mask = (64'd1 << w) - 1;
    a &= mask;
    b &= mask;
    if (sb) begin
      t  = a - b;
      co = (a >= b);
    end else begin
      t  = a + b;
      co = ((t >> w) & 1) != 0;
    end
    s   = t & mask;
    sa  = ((a >> (w - 1)) & 1) != 0;
    sbb = ((b >> (w - 1)) & 1) != 0;
    ss  = ((s >> (w - 1)) & 1) != 0;
    ov  = sb ? (sa != sbb && ss != sa) : (sa == sbb && ss != sa);
  endfunction

  task automatic set_run(bit v);
    run0 = (sel == 0) ? v : 1'b0;
    run1 = (sel == 1) ? v : 1'b0;
    run2 = (sel == 2) ? v : 1'b0;
  endtask

  task automatic do_op(int s, bit sb, logic [31:0] a, logic [31:0] b, bit ac);
    longint unsigned es;
    bit ec, eo;
    int cnt;
    model(W[s], sb, ac ? prev_sum[s] : longint'(a), longint'(b), es, ec, eo);
    sel = s;
    a_in = a; b_in = b; sub = sb; acc = ac;
    set_run(1'b1);
    @(negedge clk);
    set_run(1'b0);
    check("busy_start", 64'(o_busy), 64'd1);
    cnt = 0;
    while (o_busy && cnt < 64) begin
      check("hold_sum", 64'(o_sum), prev_sum[s]);
      check("no_early_done", 64'(o_done), 64'd0);
      a_in = $urandom; b_in = $urandom;
      sub = 1'($urandom_range(0, 1)); acc = 1'($urandom_range(0, 1));
      set_run(1'($urandom_range(0, 1)));
      cnt++;
      @(negedge clk);
    end
    check("latency", 64'(cnt), 64'(NS[s]));
    check("done", 64'(o_done), 64'd1);
    check("sum", 64'(o_sum), es);
    check("co", 64'(o_co), 64'(ec));
    check("ov", 64'(o_ov), 64'(eo));
    set_run(1'($urandom_range(0, 1)));
    @(negedge clk);
    set_run(1'b0);
    check("done_pulse", 64'(o_done), 64'd0);
    check("idle_busy", 64'(o_busy), 64'd0);
    prev_sum[s] = es; prev_co[s] = ec; prev_ov[s] = eo;
  endtask

  task automatic reset_all();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin prev_sum[i] = 0; prev_co[i] = 0; prev_ov[i] = 0; end
  endtask

  task automatic reset_midop(int s);
    bit saw_done;
    sel = s;
    a_in = 32'h1234_5678; b_in = 32'h0101_0101; sub = 1'b0; acc = 1'b0;
    set_run(1'b1);
    @(negedge clk);
    set_run(1'b0);
    if (NS[s] > 1) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    check("rst_sum", 64'(o_sum), 64'd0);
    check("rst_co", 64'(o_co), 64'd0);
    check("rst_ov", 64'(o_ov), 64'd0);
    saw_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_done) saw_done = 1'b1;
    end
    check("no_done_after_rst", 64'(saw_done), 64'd0);
    for (int i = 0; i < 3; i++) begin prev_sum[i] = 0; prev_co[i] = 0; prev_ov[i] = 0; end
  endtask

  task automatic run_held(int s);
    longint unsigned es;
    bit ec, eo;
    int c1, c2;
    sel = s;
    a_in = 32'h0000_1357; b_in = 32'h0000_0246; sub = 1'b0; acc = 1'b0;
    model(W[s], 1'b0, 64'h1357, 64'h0246, es, ec, eo);
    set_run(1'b1);
    c1 = 0;
    do begin @(negedge clk); c1++; end while (!o_done && c1 < 64);
    check("held_first_done", 64'(o_done), 64'd1);
    c2 = 0;
    do begin @(negedge clk); c2++; end while (!o_done && c2 < 64);
    check("held_period", 64'(c2), 64'(NS[s] + 2));
    check("held_sum", 64'(o_sum), es);
    set_run(1'b0);
    @(negedge clk);
    check("held_stop", 64'(o_done), 64'd0);
    prev_sum[s] = es; prev_co[s] = ec; prev_ov[s] = eo;
  endtask

  initial begin
    longint unsigned top, all;
    rst = 1'b1; sub = 1'b0; acc = 1'b0; a_in = '0; b_in = '0;
    run0 = 1'b0; run1 = 1'b0; run2 = 1'b0; sel = 0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      check("reset_sum", 64'(o_sum), 64'd0);
      check("reset_flags", {61'd0, o_co, o_ov, o_busy}, 64'd0);
      check("reset_done", 64'(o_done), 64'd0);
    end
    reset_all();

    for (int s = 0; s < 3; s++) begin
      top = 64'd1 << (W[s] - 1);
      all = (64'd1 << W[s]) - 1;
      do_op(s, 1'b0, 32'h1234, 32'h1111, 1'b0);
      do_op(s, 1'b0, 32'(all), 32'h0001, 1'b0);
      do_op(s, 1'b0, 32'(top - 1), 32'h0001, 1'b0);
      do_op(s, 1'b1, 32'h0005, 32'h0007, 1'b0);
      do_op(s, 1'b1, 32'(top), 32'h0001, 1'b0);
      do_op(s, 1'b0, 32'h00FF, 32'h0001, 1'b0);
      do_op(s, 1'b0, 32'hFFFF, 32'h0001, 1'b0);
      reset_midop(s);
      do_op(s, 1'b0, 32'h1234, 32'h1111, 1'b0);
      run_held(s);
      for (int i = 0; i < 20; i++)
        do_op(s, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    end

`ifdef MULTICYCLE_ADDER_ACCUM_EN
    reset_all();
    do_op(0, 1'b0, 32'hAAAA, 32'h0010, 1'b1);
    do_op(0, 1'b0, 32'h5555, 32'h0005, 1'b1);
    do_op(0, 1'b1, 32'h1234, 32'h0015, 1'b1);
    for (int i = 0; i < 10; i++)
      do_op(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
